// File: rtl/riscv_lsu.sv
// Load-store unit: one request/grant/response handshake per memory instruction, stalling the core until it completes.
// Optional macro LSU_MISALIGN_EXC_EN adds lsu_misalign_o and suppresses misaligned requests.
module riscv_lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [2:0]        lsu_size_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [DATA_W-1:0] lsu_data_i,
   output logic [DATA_W-1:0] lsu_data_o,
   output logic              lsu_stall_req_o,
`ifdef LSU_MISALIGN_EXC_EN
   output logic              lsu_misalign_o,
`endif
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [DATA_W-1:0] data_rdata_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          size_q, size_d;
   logic [1:0]          off_q, off_d;

   logic                misalign;
   logic                issue;
   logic [3:0]          be_calc;
   logic [DATA_W-1:0]   wdata_calc;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;

`ifdef LSU_MISALIGN_EXC_EN
   always_comb begin
      misalign = 1'b0;
      unique case (lsu_size_i)
         3'd1, 3'd5: misalign = lsu_addr_i[0];
         3'd2:       misalign = (lsu_addr_i[1:0] != 2'b00);
         default:    misalign = 1'b0;
      endcase
   end
   assign lsu_misalign_o = arstn_i & lsu_req_i & (state_q == IDLE) & misalign;
`else
   assign misalign = 1'b0;
`endif

   assign issue = lsu_req_i & ~misalign;

   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = lsu_data_i;
      unique case (lsu_size_i)
         3'd0, 3'd4: be_calc = 4'b0001 << lsu_addr_i[1:0];
         3'd1, 3'd5: be_calc = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
         default:    be_calc = 4'b1111;
      endcase
      // BU/HU codes share the B/H replication; all other codes pass rs2 through.
      unique case (lsu_size_i[1:0])
         2'd0:    wdata_calc = {4{lsu_data_i[7:0]}};
         2'd1:    wdata_calc = {2{lsu_data_i[15:0]}};
         default: wdata_calc = lsu_data_i;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 3'd0;
         off_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         off_q   <= off_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (issue) state_d = REQ;
         REQ:     if (data_gnt_i) state_d = WAIT;
         WAIT:    if (data_rvalid_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      off_d   = off_q;
      unique case (state_q)
         IDLE: begin
            if (issue) begin
               req_d   = 1'b1;
               we_d    = lsu_we_i;
               be_d    = be_calc;
               addr_d  = {lsu_addr_i[ADDR_W-1:2], 2'b00};
               wdata_d = wdata_calc;
               size_d  = lsu_size_i;
               off_d   = lsu_addr_i[1:0];
            end
         end
         REQ:     if (data_gnt_i) req_d = 1'b0;
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = data_rdata_i[7:0];
      unique case (off_q)
         2'd0: byte_sel = data_rdata_i[7:0];
         2'd1: byte_sel = data_rdata_i[15:8];
         2'd2: byte_sel = data_rdata_i[23:16];
         2'd3: byte_sel = data_rdata_i[31:24];
         default: byte_sel = data_rdata_i[7:0];
      endcase
      half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      unique case (size_q)
         3'd0:    lsu_data_o = {{24{byte_sel[7]}}, byte_sel};
         3'd4:    lsu_data_o = {24'd0, byte_sel};
         3'd1:    lsu_data_o = {{16{half_sel[15]}}, half_sel};
         3'd5:    lsu_data_o = {16'd0, half_sel};
         default: lsu_data_o = data_rdata_i;
      endcase
   end

   // A misaligned request is rejected in IDLE without stalling the core.
   assign lsu_stall_req_o = arstn_i & lsu_req_i
                          & ~((state_q == IDLE) & misalign)
                          & ~((state_q == WAIT) & data_rvalid_i);

   assign data_req_o   = req_q;
   assign data_we_o    = we_q;
   assign data_be_o    = be_q;
   assign data_addr_o  = addr_q;
   assign data_wdata_o = wdata_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu; expectations come from an arithmetic reference model.
module tb_riscv_lsu;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o;
`ifdef LSU_MISALIGN_EXC_EN
   logic        lsu_misalign_o;
`endif
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   int n_checks = 0;
   int n_pass   = 0;
   int n_txn    = 0;

   always #5 clk_i = ~clk_i;

   riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i           (clk_i),
      .arstn_i         (arstn_i),
      .lsu_req_i       (lsu_req_i),
      .lsu_we_i        (lsu_we_i),
      .lsu_size_i      (lsu_size_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_data_i      (lsu_data_i),
      .lsu_data_o      (lsu_data_o),
      .lsu_stall_req_o (lsu_stall_req_o),
`ifdef LSU_MISALIGN_EXC_EN
      .lsu_misalign_o  (lsu_misalign_o),
`endif
      .data_req_o      (data_req_o),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_rdata_i    (data_rdata_i)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (txn %0d, t=%0t)", tag, got, exp, n_txn, $time);
   endtask

   function automatic logic [31:0] ref_be(input int size, input longint addr);
      longint k = addr % 4;
      if (size == 0 || size == 4) return 32'(1 << k);
      if (size == 1 || size == 5) return (k >= 2) ? 32'hC : 32'h3;
      return 32'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input int size, input longint data);
      longint v;
      if (size == 0 || size == 4)      v = (data % 256) * 64'h0101_0101;
      else if (size == 1 || size == 5) v = (data % 65536) * 64'h0001_0001;
      else                             v = data;
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_load(input int size, input longint addr, input longint rd);
      longint v;
      if (size == 0 || size == 4) begin
         v = (rd / (longint'(1) << (8 * (addr % 4)))) % 256;
         if (size == 0 && v >= 128) v = v - 256;
      end else if (size == 1 || size == 5) begin
         v = (rd / (longint'(1) << (16 * ((addr / 2) % 2)))) % 65536;
         if (size == 1 && v >= 32768) v = v - 65536;
      end else begin
         v = rd;
      end
      return v[31:0];
   endfunction

   function automatic bit ref_misaligned(input int size, input longint addr);
      if (size == 1 || size == 5) return (addr % 2) != 0;
      if (size == 2) return (addr % 4) != 0;
      return 1'b0;
   endfunction

   task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input int gd, input int rdly, input logic [31:0] rdata);
      int          stalls = 0;
      int          sz     = int'(size);
      longint      a      = longint'(addr);
      logic [31:0] exp_a  = 32'((a / 4) * 4);
      n_txn++;
      @(negedge clk_i);
      lsu_req_i     = 1'b1;
      lsu_we_i      = we;
      lsu_size_i    = size;
      lsu_addr_i    = addr;
      lsu_data_i    = wd;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'($urandom_range(0, 1));
      data_rdata_i  = $urandom;
      #1;
`ifdef LSU_MISALIGN_EXC_EN
      if (ref_misaligned(sz, a)) begin
         check_eq("misalign_flag", 32'(lsu_misalign_o), 32'd1);
         check_eq("misalign_stall", 32'(lsu_stall_req_o), 32'd0);
         @(negedge clk_i);
         lsu_req_i     = 1'b0;
         data_rvalid_i = 1'b0;
         #1;
         check_eq("misalign_noreq", 32'(data_req_o), 32'd0);
         check_eq("misalign_clear", 32'(lsu_misalign_o), 32'd0);
         $display("txn %0d misaligned we=%0d size=%0d addr=0x%08h rejected", n_txn, we, size, addr);
         return;
      end
      check_eq("misalign_flag", 32'(lsu_misalign_o), 32'd0);
`else
      if (ref_misaligned(sz, a)) $display("txn %0d misaligned access proceeds truncated", n_txn);
`endif
      if (lsu_stall_req_o) stalls++;
      check_eq("idle_req", 32'(data_req_o), 32'd0);
      for (int g = 0; g <= gd; g++) begin
         @(negedge clk_i);
         data_gnt_i    = (g == gd);
         data_rvalid_i = (g == gd) ? 1'($urandom_range(0, 1)) : 1'b0;
         data_rdata_i  = $urandom;
         #1;
         if (lsu_stall_req_o) stalls++;
         check_eq("req", 32'(data_req_o), 32'd1);
         check_eq("addr", data_addr_o, exp_a);
         check_eq("be", 32'(data_be_o), ref_be(sz, a));
         check_eq("we", 32'(data_we_o), 32'(we));
         check_eq("wdata", data_wdata_o, ref_wdata(sz, longint'(wd)));
      end
      for (int r = 0; r <= rdly; r++) begin
         @(negedge clk_i);
         data_gnt_i    = 1'b0;
         data_rvalid_i = (r == rdly);
         data_rdata_i  = (r == rdly) ? rdata : $urandom;
         #1;
         if (lsu_stall_req_o) stalls++;
         check_eq("wait_req", 32'(data_req_o), 32'd0);
      end
      if (!we) check_eq("load_data", lsu_data_o, ref_load(sz, a, longint'(rdata)));
      check_eq("stall_cycles", 32'(stalls), 32'(2 + gd + rdly));
      $display("txn %0d we=%0d size=%0d addr=0x%08h wd=0x%08h gnt_dly=%0d rv_dly=%0d rdata=0x%08h lsu_data=0x%08h stalls=%0d",
               n_txn, we, size, addr, wd, gd, rdly, rdata, lsu_data_o, stalls);
   endtask

   // Idle gap with stray handshake inputs that the IDLE state must ignore.
   task automatic idle_gap();
      @(negedge clk_i);
      lsu_req_i     = 1'b0;
      data_gnt_i    = 1'($urandom_range(0, 1));
      data_rvalid_i = 1'($urandom_range(0, 1));
      #1;
      check_eq("gap_stall", 32'(lsu_stall_req_o), 32'd0);
      check_eq("gap_req", 32'(data_req_o), 32'd0);
      @(negedge clk_i);
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      #1;
      check_eq("gap_req2", 32'(data_req_o), 32'd0);
   endtask

   task automatic reset_mid(input bit in_wait);
      n_txn++;
      @(negedge clk_i);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h40; lsu_data_i = 32'h0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      @(negedge clk_i);
      data_gnt_i = in_wait;
      if (in_wait) begin
         @(negedge clk_i);
         data_gnt_i = 1'b0;
      end
      #1;
      check_eq("pre_rst_req", 32'(data_req_o), in_wait ? 32'd0 : 32'd1);
      arstn_i = 1'b0;
      #1;
      check_eq("rst_req", 32'(data_req_o), 32'd0);
      check_eq("rst_stall", 32'(lsu_stall_req_o), 32'd0);
      check_eq("rst_be", 32'(data_be_o), 32'd0);
      check_eq("rst_addr", data_addr_o, 32'd0);
      @(negedge clk_i);
      arstn_i = 1'b1; lsu_req_i = 1'b0;
      data_gnt_i = 1'b1; data_rvalid_i = 1'b1;
      #1;
      check_eq("post_rst_stall", 32'(lsu_stall_req_o), 32'd0);
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      #1;
      check_eq("post_rst_req", 32'(data_req_o), 32'd0);
      $display("txn %0d reset asserted in %s, stale handshake ignored", n_txn, in_wait ? "WAIT" : "REQ");
   endtask

   initial begin
      arstn_i = 1'b0; lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
      lsu_addr_i = 32'h0; lsu_data_i = 32'h0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
      #12;
      check_eq("reset_req", 32'(data_req_o), 32'd0);
      check_eq("reset_we", 32'(data_we_o), 32'd0);
      check_eq("reset_be", 32'(data_be_o), 32'd0);
      check_eq("reset_addr", data_addr_o, 32'd0);
      check_eq("reset_wdata", data_wdata_o, 32'd0);
      check_eq("reset_stall", 32'(lsu_stall_req_o), 32'd0);
      @(negedge clk_i);
      lsu_req_i = 1'b0;
      arstn_i   = 1'b1;

      do_access(1'b0, 3'd0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234);
      idle_gap();
      do_access(1'b0, 3'd5, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000);
      do_access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_0000);
      do_access(1'b1, 3'd0, 32'h0000_0001, 32'h1234_56AB, 3, 1, 32'h0);
      do_access(1'b0, 3'd2, 32'h0000_0010, 32'h0, 0, 2, 32'h1111_2222);
      do_access(1'b0, 3'd2, 32'h0000_0014, 32'h0, 0, 2, 32'h3333_4444);
      do_access(1'b0, 3'd2, 32'h0000_0006, 32'h0, 1, 0, 32'hCAFE_F00D);
      do_access(1'b1, 3'd1, 32'h0000_0003, 32'hA5A5_5A5A, 0, 0, 32'h0);
      idle_gap();
      reset_mid(1'b1);
      do_access(1'b0, 3'd2, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF);
      reset_mid(1'b0);
      do_access(1'b0, 3'd4, 32'h0000_0102, 32'h0, 1, 1, 32'h00F0_0000);

      for (int i = 0; i < 80; i++) begin
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 3) == 0) idle_gap();
      end
      idle_gap();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit controller between the core and the data memory port. It takes the decoder's memory controls (mem_req, mem_we, mem_size) plus the ALU address and rs2 data. It sequences one request/grant/response transaction per instruction and stalls the core until that transaction completes. It also generates byte enables, replicates store data and sign- or zero-extends load data.

Parameters:
ADDR_W, 32, address width (word-aligned memory address output)
DATA_W, 32, data width; only 32 is supported

Ports:
clk_i  in  1  clock, rising edge
arstn_i  in  1  asynchronous active-low reset
lsu_req_i  in  1  memory instruction in decode (mem_req_o from the decoder)
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
lsu_addr_i  in  32  byte address from the ALU
lsu_data_i  in  32  store data (rs2)
lsu_data_o  out  32  extended load data, valid in the completion cycle
lsu_stall_req_o  out  1  hold PC/pipeline while high
data_req_o  out  1  memory request
data_we_o  out  1  memory write enable
data_be_o  out  4  byte enables
data_addr_o  out  32  {addr[31:2],2'b00}
data_wdata_o  out  32  replicated store data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  response (read data or write acknowledge)
data_rdata_i  in  32  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- IDLE:
  - If lsu_req_i=1: latch addr, we, size, be and wdata into registers; set data_req_o<=1; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - data_req_o is held at 1 and all data_* outputs are held constant.
  - If data_gnt_i=1: data_req_o<=0; go to WAIT.
- WAIT:
  - If data_rvalid_i=1: go to IDLE.
  - A grant-cycle rvalid is not accepted; rvalid is only sampled in WAIT.
- lsu_stall_req_o is combinational: lsu_req_i & ~(state==WAIT & data_rvalid_i). It is 0 while arstn_i=0.
- Minimum access latency is 3 cycles (IDLE, REQ with gnt, WAIT with rvalid), giving 2 stall cycles. Every extra gnt or rvalid wait cycle adds one stall cycle.
- Stores wait for rvalid exactly like loads.
- Core inputs must remain stable while stalled. The LSU uses only the latched copies after IDLE.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W and any undefined size code (3, 6, 7): 4'b1111.
- Store data:
  - B: {4{data[7:0]}}.
  - H: {2{data[15:0]}}.
  - W: data unchanged.
- Load data is combinational from data_rdata_i, using the latched addr[1:0] and size:
  - B: byte selected by addr[1:0], sign-extended.
  - BU: same byte, zero-extended.
  - H: half selected by addr[1], sign-extended.
  - HU: same half, zero-extended.
  - W: data_rdata_i unchanged.
  - lsu_data_o is meaningful only when state==WAIT & data_rvalid_i; otherwise it is don't-care but must not be X-propagating.
- Back-to-back memory instructions: after completion the FSM returns to IDLE. The next instruction is captured on the following edge (one IDLE cycle between requests).
- Reset values: data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0, state=IDLE.
- Reset mid-transaction: data_req_o drops immediately (asynchronously). Any later gnt or rvalid is ignored until a new request is issued from IDLE.

Optional Feature:
Macro: LSU_MISALIGN_EXC_EN.
- Defined:
  - Adds output lsu_misalign_o (1 bit).
  - In IDLE, a misaligned request (H/HU with addr[0]=1, or W with addr[1:0]!=0) issues no memory request and stays in IDLE.
  - lsu_misalign_o is high combinationally for that cycle, and lsu_stall_req_o=0 that cycle.
- Not defined:
  - The port is absent.
  - Misaligned accesses proceed with the low address bits truncated as per the byte-enable rules (H at addr 0x3 uses be 4'b1100; W ignores addr[1:0]).

Test Plan:
- LB at 0x1003, rdata 0x80FF_1234, gnt and rvalid immediate -> data_req_o 1 cycle, be=4'b1000, addr=0x1000, stall high 2 cycles, lsu_data_o=0xFFFF_FF80.
- LHU at 0x2002, rdata 0xBEEF_0000 -> be=4'b1100, lsu_data_o=0x0000_BEEF; same case as LH -> 0xFFFF_BEEF.
- SB at 0x0001, data 0x1234_56AB, gnt delayed 3 cycles -> data_req_o held 4 cycles with constant outputs, wdata=0xABAB_ABAB, be=4'b0010, data_we_o=1, stall released only on rvalid.
- Two back-to-back LW (0x10, 0x14) with rvalid delayed 2 cycles -> two separate handshakes, one IDLE cycle between them, lsu_data_o equals each word in its rvalid cycle.
- arstn_i low while in WAIT -> data_req_o=0 and stall=0 immediately; rvalid after release ignored; next LW completes normally.
- With LSU_MISALIGN_EXC_EN, LW at 0x6 -> lsu_misalign_o=1 for 1 cycle, data_req_o stays 0, stall=0; without the macro -> access issued at 0x4, be=4'b1111.
